uart_tx_fifo: RTL and testbench

//  Buffered UART transmitter (8N1/8N2) driving the serial line into the SoC UART receive input (rx_i)
//  for the board-level debug/loader path. Bytes enter through a req/ack handshake and queue in a FIFO.

---
 rtl/uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8N1/8N2 UART transmitter for the board-level debug/loader path.
//   Bytes are accepted through a req/ack handshake into a small FIFO and are
//   serialized LSB-first at one bit per DIVIDER clock cycles. While bytes are
//   queued, frames are sent back-to-back with no idle gap between them.
//
// Parameters
//   DIVIDER    clock cycles per serial bit (>= 2)
//   FIFO_DEPTH byte queue depth (power of two, >= 2)
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports
//   clk_i    in   system clock, all state on the rising edge
//   arst_i   in   asynchronous reset, active-high
//   req_i    in   byte write request
//   data_i   in   byte to send, taken on an edge where req_i & ack_o
//   ack_o    out  FIFO can accept a byte (not full), decoded from the count
//   tx_o     out  serial line, idle high, registered
//   busy_o   out  frame in progress or bytes still queued, registered
//   level_o  out  bytes queued, not counting the byte being shifted out
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DIVIDER    = 868,
    parameter int FIFO_DEPTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic                          req_i,
    input  logic [7:0]                    data_i,
    output logic                          ack_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int CNT_W = $clog2(DIVIDER);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] BAUD_ZERO   = {CNT_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_EMPTY   = {LVL_W{1'b0}};
    localparam logic [0:0]       STOP_LAST   = 1'(STOP_BITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  count_r;

    // Serializer state
    logic [1:0]        state_r;
    logic [CNT_W-1:0]  baud_cnt_r;
    logic [2:0]        bit_cnt_r;
    logic [0:0]        stop_cnt_r;
    logic [7:0]        shift_r;
    logic              tx_r;
    logic              busy_r;

    // Next-state values
    logic              push_s;
    logic              pop_s;
    logic              fifo_avail_s;
    logic              baud_done_s;
    logic [7:0]        fifo_head_s;
    logic [LVL_W-1:0]  count_n_s;
    logic [1:0]        state_n_s;
    logic [CNT_W-1:0]  baud_n_s;
    logic [2:0]        bit_n_s;
    logic [0:0]        stop_n_s;
    logic [7:0]        shift_n_s;
    logic              tx_n_s;
    logic              busy_n_s;

    assign ack_o        = (count_r != LVL_FULL);
    assign push_s       = req_i & ack_o;
    assign fifo_avail_s = (count_r != LVL_EMPTY);
    assign fifo_head_s  = mem_r[rd_ptr_r];
    assign baud_done_s  = (baud_cnt_r == BAUD_ZERO);

    assign tx_o    = tx_r;
    assign busy_o  = busy_r;
    assign level_o = count_r;

    // Occupancy update; a push and a pop on the same edge cancel out
    always_comb begin
        count_n_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_n_s = count_r + LVL_W'(1);
            2'b01:   count_n_s = count_r - LVL_W'(1);
            default: count_n_s = count_r;
        endcase
    end

    // Frame sequencer: start bit, eight data bits LSB-first, stop bit(s)
    always_comb begin
        state_n_s = state_r;
        baud_n_s  = baud_cnt_r;
        bit_n_s   = bit_cnt_r;
        stop_n_s  = stop_cnt_r;
        shift_n_s = shift_r;
        tx_n_s    = tx_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tx_n_s = 1'b1;
                if (fifo_avail_s) begin
                    pop_s     = 1'b1;
                    shift_n_s = fifo_head_s;
                    baud_n_s  = BAUD_RELOAD;
                    tx_n_s    = 1'b0;
                    state_n_s = ST_START;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    tx_n_s    = shift_r[0];
                    bit_n_s   = 3'd0;
                    baud_n_s  = BAUD_RELOAD;
                    state_n_s = ST_DATA;
                end else begin
                    baud_n_s  = baud_cnt_r - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    baud_n_s = BAUD_RELOAD;
                    if (bit_cnt_r == 3'd7) begin
                        tx_n_s    = 1'b1;
                        stop_n_s  = 1'b0;
                        state_n_s = ST_STOP;
                    end else begin
                        // shift_r[1] is the bit that becomes shift_r[0] after this edge
                        shift_n_s = {1'b0, shift_r[7:1]};
                        tx_n_s    = shift_r[1];
                        bit_n_s   = bit_cnt_r + 3'd1;
                    end
                end else begin
                    baud_n_s = baud_cnt_r - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    baud_n_s = BAUD_RELOAD;
                    if (stop_cnt_r == STOP_LAST) begin
                        // Chain straight into the next start bit when data is waiting
                        if (fifo_avail_s) begin
                            pop_s     = 1'b1;
                            shift_n_s = fifo_head_s;
                            tx_n_s    = 1'b0;
                            state_n_s = ST_START;
                        end else begin
                            tx_n_s    = 1'b1;
                            state_n_s = ST_IDLE;
                        end
                    end else begin
                        stop_n_s = stop_cnt_r + 1'b1;
                    end
                end else begin
                    baud_n_s = baud_cnt_r - CNT_W'(1);
                end
            end
            default: begin
                tx_n_s    = 1'b1;
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Busy looks ahead so it rises on the push edge and falls with the last stop cycle
    always_comb begin
        busy_n_s = (state_n_s != ST_IDLE) || (count_n_s != LVL_EMPTY);
    end

    // FIFO data array; contents need no reset because count gates every read
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= LVL_EMPTY;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_n_s;
        end
    end

    // Serializer registers; reset drives the line idle high at once
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            baud_cnt_r <= baud_n_s;
            bit_cnt_r  <= bit_n_s;
            stop_cnt_r <= stop_n_s;
            shift_r    <= shift_n_s;
            tx_r       <= tx_n_s;
            busy_r     <= busy_n_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Scoreboard bench for uart_tx_fifo with DIVIDER=4. Accepted bytes are queued
//   as expected frames; a monitor decodes every frame on tx and compares it
//   cycle by cycle against the head of the queue. A second instance with two
//   stop bits is checked directly for its frame shape.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       arst;
    logic       req, req2;
    logic [7:0] data, data2;
    logic       ack, ack2, tx, tx2, busy, busy2;
    logic [3:0] level, level2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] sb[$];
    int         starts[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.DIVIDER(DIV), .FIFO_DEPTH(8), .STOP_BITS(1)) dut (
        .clk_i(clk), .arst_i(arst), .req_i(req), .data_i(data),
        .ack_o(ack), .tx_o(tx), .busy_o(busy), .level_o(level)
    );

    uart_tx_fifo #(.DIVIDER(DIV), .FIFO_DEPTH(8), .STOP_BITS(2)) dut2 (
        .clk_i(clk), .arst_i(arst), .req_i(req2), .data_i(data2),
        .ack_o(ack2), .tx_o(tx2), .busy_o(busy2), .level_o(level2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte for one edge; exp_acc is the hand-derived acceptance
    task automatic push(input logic [7:0] b, input logic exp_acc);
        req  = 1'b1;
        data = b;
        check("push_ack", {31'd0, ack}, {31'd0, exp_acc});
        if (exp_acc) sb.push_back(b);
        step();
        req = 1'b0;
    endtask

    task automatic push_when_ready(input logic [7:0] b);
        int n = 0;
        while (ack !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("ack_wait", {31'd0, ack}, 32'd1);
        push(b, 1'b1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
        step();
        step();
    endtask

    // Monitor: decode each frame and compare every line cycle against the expected byte
    initial begin : monitor
        logic [7:0] exp_b, got_b;
        logic       exp_bit, ok, aborted, have_exp;
        int         idx;
        forever begin
            @(negedge clk);
            if (arst === 1'b0 && tx === 1'b0) begin
                starts.push_back(cyc);
                have_exp = (sb.size() > 0);
                exp_b    = 8'h00;
                if (have_exp) exp_b = sb.pop_front();
                ok      = 1'b1;
                aborted = 1'b0;
                got_b   = 8'h00;
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) @(negedge clk);
                    if (arst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    idx = c / DIV;
                    if (idx == 0) exp_bit = 1'b0;
                    else if (idx <= 8) exp_bit = exp_b[idx-1];
                    else exp_bit = 1'b1;
                    if (tx !== exp_bit) ok = 1'b0;
                    if (idx >= 1 && idx <= 8 && (c % DIV) == 2) got_b[idx-1] = tx;
                end
                if (!aborted) begin
                    checks++;
                    if (!have_exp) begin
                        errors++;
                        $display("FAIL unexpected_frame actual=%02h expected=none", got_b);
                    end else if (!ok) begin
                        errors++;
                        $display("FAIL frame actual=%02h expected=%02h (bit timing or value)", got_b, exp_b);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int n, m, lows;
        arst  = 1'b1;
        req   = 1'b0;
        data  = 8'h00;
        req2  = 1'b0;
        data2 = 8'h00;
        repeat (3) step();

        // Reset state of both instances
        check("rst_tx",     {31'd0, tx},    32'd1);
        check("rst_ack",    {31'd0, ack},   32'd1);
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_level",  {28'd0, level}, 32'd0);
        check("rst2_tx",    {31'd0, tx2},   32'd1);
        check("rst2_level", {28'd0, level2}, 32'd0);
        arst = 1'b0;
        step();

        // Test 1: single byte 0x55, one-edge latency to start bit
        push(8'h55, 1'b1);
        check("t1_tx_before", {31'd0, tx},    32'd1);
        check("t1_busy",      {31'd0, busy},  32'd1);
        check("t1_level1",    {28'd0, level}, 32'd1);
        step();
        check("t1_latency",   {31'd0, tx},    32'd0);
        check("t1_level0",    {28'd0, level}, 32'd0);
        wait_idle(200);

        // Test 2: two bytes back-to-back, no gap, busy falls after 80 cycles
        starts.delete();
        push(8'hA3, 1'b1);
        push(8'h0F, 1'b1);
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            step();
            n++;
        end
        check("t2_frames", starts.size(), 32'd2);
        if (starts.size() == 2) begin
            check("t2_period",   starts[1] - starts[0], FRAME);
            check("t2_busy_end", cyc - starts[0],       2 * FRAME);
        end
        wait_idle(50);

        // Test 3: eleven bytes at full rate; first pops at once, so bytes 9 and 10 drop
        for (int i = 0; i < 11; i++) begin
            push(8'h10 + 8'(i), (i < 9) ? 1'b1 : 1'b0);
        end
        check("t3_level_full", {28'd0, level}, 32'd8);
        check("t3_ack_full",   {31'd0, ack},   32'd0);
        n = 0;
        while (level === 4'd8 && n < 100) begin
            step();
            n++;
        end
        check("t3_level_pop",  {28'd0, level}, 32'd7);
        check("t3_ack_return", {31'd0, ack},   32'd1);
        wait_idle(600);

        // Test 4: reset during data bit 3 of 0xFF with three bytes queued
        push(8'hFF, 1'b1);
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        repeat (15) step();
        check("t4_bit3",       {31'd0, tx},    32'd1);
        check("t4_queued",     {28'd0, level}, 32'd3);
        #2;
        arst = 1'b1;
        sb.delete();
        #1;
        check("t4_rst_tx",    {31'd0, tx},    32'd1);
        check("t4_rst_level", {28'd0, level}, 32'd0);
        check("t4_rst_busy",  {31'd0, busy},  32'd0);
        check("t4_rst_ack",   {31'd0, ack},   32'd1);
        step();
        step();
        arst = 1'b0;
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (tx !== 1'b1) lows++;
        end
        check("t4_no_frames", lows, 32'd0);
        check("t4_level_after", {28'd0, level}, 32'd0);

        // Test 5: two stop bits, byte 0x00 -> 36 low cycles then 8 high busy cycles
        req2  = 1'b1;
        data2 = 8'h00;
        check("t5_ack", {31'd0, ack2}, 32'd1);
        step();
        req2 = 1'b0;
        step();
        n = 0;
        while (tx2 === 1'b0 && n < 100) begin
            n++;
            step();
        end
        check("t5_low_cycles", n, 32'd36);
        m = 0;
        while (busy2 === 1'b1 && tx2 === 1'b1 && m < 100) begin
            m++;
            step();
        end
        check("t5_stop_cycles", m, 32'd8);
        repeat (3) step();
        check("t5_idle_tx",   {31'd0, tx2},   32'd1);
        check("t5_idle_busy", {31'd0, busy2}, 32'd0);

        // Test 6: push on the pop edge at level 3, then 20 bytes through the wrapping FIFO
        push(8'h60, 1'b1);
        push(8'h61, 1'b1);
        push(8'h62, 1'b1);
        push(8'h63, 1'b1);
        repeat (37) step();
        check("t6_level_before", {28'd0, level}, 32'd3);
        push(8'h64, 1'b1);
        check("t6_level_same",   {28'd0, level}, 32'd3);
        check("t6_next_start",   {31'd0, tx},    32'd0);
        for (int i = 0; i < 15; i++) begin
            push_when_ready(8'h65 + 8'(i));
        end
        wait_idle(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
